// File: rtl/icache_axi_refill_engine.sv
// ---------------------------------------------------------------------------
// icache_axi_refill_engine
//   Refill engine between the L1 instruction-cache miss port and an AXI4 read
//   channel (AR/R only). Misses and non-cacheable fetches are queued in a
//   circular tracker and issued as AXI bursts in order. R beats are assembled
//   into full lines and returned to the cache. A flush drops queued requests
//   and kills refills already on the bus.
//
// Optional build macro: ICACHE_REFILL_ERR_EN
//   defined   : SLVERR/DECERR on any beat sets a sticky error that is returned
//               on rtrn_err_o
//   undefined : r_resp_i is ignored and rtrn_err_o is tied to 0
//
// Ports
//   clk_i, rst_ni                        clock, synchronous active-low reset
//   flush_i                              drop queued requests, kill in-flight refills
//   req_valid_i/req_ready_o              cache request handshake
//   req_paddr_i, req_nc_i, req_tid_i     request address, non-cacheable flag, tag
//   rtrn_vld_o, rtrn_data_o,
//   rtrn_tid_o, rtrn_err_o               one-cycle return pulse with held payload
//   ar_*                                 AXI read address channel
//   r_*                                  AXI read data channel
// ---------------------------------------------------------------------------
module icache_axi_refill_engine #(
  parameter int unsigned PlenWidth      = 56,
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiDataWidth   = 64,
  parameter int unsigned AxiIdWidth     = 4,
  parameter int unsigned LineWidth      = 128,
  parameter int unsigned TidWidth       = 2,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned RdTxId         = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [PlenWidth-1:0]    req_paddr_i,
  input  logic                    req_nc_i,
  input  logic [TidWidth-1:0]     req_tid_i,
  output logic                    rtrn_vld_o,
  output logic [LineWidth-1:0]    rtrn_data_o,
  output logic [TidWidth-1:0]     rtrn_tid_o,
  output logic                    rtrn_err_o,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [AxiAddrWidth-1:0] ar_addr_o,
  output logic [7:0]              ar_len_o,
  output logic [2:0]              ar_size_o,
  output logic [1:0]              ar_burst_o,
  output logic [AxiIdWidth-1:0]   ar_id_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [AxiDataWidth-1:0] r_data_i,
  input  logic [1:0]              r_resp_i,
  input  logic                    r_last_i
);
  localparam int unsigned Words   = LineWidth / AxiDataWidth;
  localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned BeatW   = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned LineOff = $clog2(LineWidth / 8);
  localparam int unsigned BeatOff = $clog2(AxiDataWidth / 8);

  // Tracker storage
  logic [PlenWidth-1:0]      addr_q [MaxOutstanding];
  logic [TidWidth-1:0]       tid_q  [MaxOutstanding];
  logic [MaxOutstanding-1:0] nc_q;
  logic [MaxOutstanding-1:0] valid_q, valid_d;
  logic [MaxOutstanding-1:0] issued_q, issued_d;
  logic [MaxOutstanding-1:0] killed_q, killed_d;
  logic [PtrW-1:0]           alloc_q, alloc_d, issue_q, issue_d, retire_q, retire_d;
  logic [PtrW:0]             count_q, count_d;

  // Line assembly
  logic [BeatW-1:0]          beat_q, beat_d;
  logic [LineWidth-1:0]      line_q, line_d;
  logic                      err_d;

  // Return registers
  logic                      rtrn_vld_q;
  logic [LineWidth-1:0]      rtrn_data_q;
  logic [TidWidth-1:0]       rtrn_tid_q;

  logic req_fire_s, ar_fire_s, r_fire_s, r_done_s;
  logic [AxiAddrWidth-1:0] ar_base_s;
  logic unused_s;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) return '0;
    else return p + PtrW'(1);
  endfunction

  // Handshakes; readiness comes from the registered count so a retire in the
  // same cycle never frees a slot early.
  assign req_ready_o = (count_q != (PtrW+1)'(MaxOutstanding)) & ~flush_i;
  assign req_fire_s  = req_valid_i & req_ready_o;
  assign ar_valid_o  = valid_q[issue_q] & ~issued_q[issue_q];
  assign ar_fire_s   = ar_valid_o & ar_ready_i;
  assign r_ready_o   = valid_q[retire_q] & issued_q[retire_q];
  assign r_fire_s    = r_valid_i & r_ready_o;
  assign r_done_s    = r_fire_s & r_last_i;

  // AR fields are pure functions of the issue entry, so they are stable until accepted
  assign ar_base_s  = AxiAddrWidth'(addr_q[issue_q]);
  assign ar_addr_o  = nc_q[issue_q] ? ((ar_base_s >> BeatOff) << BeatOff)
                                    : ((ar_base_s >> LineOff) << LineOff);
  assign ar_len_o   = nc_q[issue_q] ? 8'd0 : 8'(Words - 1);
  assign ar_size_o  = 3'(BeatOff);
  assign ar_burst_o = 2'b01;
  assign ar_id_o    = AxiIdWidth'(RdTxId);

  assign rtrn_vld_o  = rtrn_vld_q;
  assign rtrn_data_o = rtrn_data_q;
  assign rtrn_tid_o  = rtrn_tid_q;
  assign unused_s    = ^r_resp_i;

  // Tracker next state: issue, retire, then flush or allocate
  always_comb begin
    valid_d  = valid_q;
    issued_d = issued_q;
    killed_d = killed_q;
    alloc_d  = alloc_q;
    issue_d  = issue_q;
    retire_d = retire_q;
    count_d  = '0;
    if (ar_fire_s) begin
      issued_d[issue_q] = 1'b1;
      issue_d           = ptr_inc(issue_q);
    end else begin
      issue_d = issue_q;
    end
    if (r_done_s) begin
      valid_d[retire_q] = 1'b0;
      retire_d          = ptr_inc(retire_q);
    end else begin
      retire_d = retire_q;
    end
    if (flush_i) begin
      // Unissued entries vanish; anything already on the bus drains silently
      for (int i = 0; i < MaxOutstanding; i++) begin
        if (valid_d[i] & ~issued_d[i]) valid_d[i] = 1'b0;
        else if (valid_d[i])           killed_d[i] = 1'b1;
        else                           killed_d[i] = killed_d[i];
      end
      alloc_d = issue_d;
    end else if (req_fire_s) begin
      valid_d[alloc_q]  = 1'b1;
      issued_d[alloc_q] = 1'b0;
      killed_d[alloc_q] = 1'b0;
      alloc_d           = ptr_inc(alloc_q);
    end else begin
      alloc_d = alloc_q;
    end
    for (int i = 0; i < MaxOutstanding; i++) begin
      count_d = count_d + (PtrW+1)'(valid_d[i]);
    end
  end

  // Beat assembly; the first beat of each refill clears the line buffer so
  // non-cacheable returns carry zeros above word 0
  always_comb begin
    beat_d = beat_q;
    line_d = line_q;
    if (r_fire_s) begin
      if (beat_q == '0) line_d = '0;
      else              line_d = line_q;
      line_d[beat_q*AxiDataWidth +: AxiDataWidth] = r_data_i;
      if (r_last_i)                            beat_d = '0;
      else if (beat_q != BeatW'(Words - 1))    beat_d = beat_q + BeatW'(1);
      else                                     beat_d = beat_q;
    end else begin
      beat_d = beat_q;
    end
  end

`ifdef ICACHE_REFILL_ERR_EN
  logic err_q, rtrn_err_q;
  // Sticky error: restarts on the first beat of each refill
  always_comb begin
    err_d = err_q;
    if (r_fire_s) err_d = ((beat_q == '0) ? 1'b0 : err_q) | r_resp_i[1];
    else          err_d = err_q;
  end

  // Error flop and its returned copy
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q      <= 1'b0;
      rtrn_err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (r_done_s & ~killed_q[retire_q] & ~flush_i) rtrn_err_q <= err_d;
    end
  end
  assign rtrn_err_o = rtrn_err_q;
`else
  assign err_d      = 1'b0;
  assign rtrn_err_o = 1'b0;
`endif

  // Tracker payload, written on allocation only
  always_ff @(posedge clk_i) begin
    if (req_fire_s) begin
      addr_q[alloc_q] <= req_paddr_i;
      tid_q[alloc_q]  <= req_tid_i;
      nc_q[alloc_q]   <= req_nc_i;
    end
  end

  // Control state, assembly buffer and return registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q     <= '0;
      issued_q    <= '0;
      killed_q    <= '0;
      alloc_q     <= '0;
      issue_q     <= '0;
      retire_q    <= '0;
      count_q     <= '0;
      beat_q      <= '0;
      line_q      <= '0;
      rtrn_vld_q  <= 1'b0;
      rtrn_data_q <= '0;
      rtrn_tid_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      issued_q <= issued_d;
      killed_q <= killed_d;
      alloc_q  <= alloc_d;
      issue_q  <= issue_d;
      retire_q <= retire_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
      line_q   <= line_d;
      if (r_done_s & ~killed_q[retire_q] & ~flush_i) begin
        rtrn_vld_q  <= 1'b1;
        rtrn_data_q <= line_d;
        rtrn_tid_q  <= tid_q[retire_q];
      end else begin
        rtrn_vld_q  <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  icache_axi_refill_engine_chk #(.BeatW(BeatW)) u_chk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .r_fire_i    (r_fire_s),
    .r_last_i    (r_last_i),
    .beat_i      (beat_q),
    .last_beat_i (nc_q[retire_q] ? BeatW'(0) : BeatW'(Words - 1))
  );
`endif
endmodule

// Protocol checker: r_last must arrive exactly on the beat implied by ar_len
module icache_axi_refill_engine_chk #(
  parameter int unsigned BeatW = 1
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic             r_fire_i,
  input logic             r_last_i,
  input logic [BeatW-1:0] beat_i,
  input logic [BeatW-1:0] last_beat_i
);
  a_beat_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_fire_i |-> (r_last_i == (beat_i == last_beat_i)));
endmodule
